// File: rtl/arp_pkg.sv
// ---------------------------------------------------------------------------
// arp_pkg
// Field widths and bundled types shared by the ARP cache and the blocks that
// talk to its query port.
//   IP_W         : width of an IPv4 address carried on a query request
//   MAC_W        : width of a MAC address carried on a query response
//   query_resp_t : response payload (miss flag + MAC)
// ---------------------------------------------------------------------------
package arp_pkg;

    localparam int IP_W  = 32;
    localparam int MAC_W = 48;

    typedef struct packed {
        logic             error;
        logic [MAC_W-1:0] mac;
    } query_resp_t;

endpackage

// File: rtl/arp_tag_fifo.sv
// ---------------------------------------------------------------------------
// arp_tag_fifo
// Small in-order FIFO holding the requester index of every query that has
// been issued to the cache but not yet answered. Head is read
// combinationally so the response can be routed in the same cycle it shows
// up.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data (ignored when full)
//   push_data  : tag to store
//   pop        : drop the head entry (ignored when empty)
//   head       : oldest stored tag
//   count      : number of stored tags (0..DEPTH)
//   empty      : count == 0
// ---------------------------------------------------------------------------
module arp_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg,  count_next;
    logic             push_ok, pop_ok;

    assign push_ok = push && (count_reg != DEPTH_CNT);
    assign pop_ok  = pop  && (count_reg != '0);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= push_data;
            end
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);

endmodule

// File: rtl/arp_cache_query_arb.sv
// ---------------------------------------------------------------------------
// arp_cache_query_arb
// Shares the single ARP cache query port between PORTS requesters.
// Requests are round-robin arbitrated into a registered output stage; the
// winning port index is queued in a tag FIFO so each in-order cache response
// is steered back to the requester that issued it.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   s_query_request_*        : per-port request (valid/ready/ip, ip port i at
//                              bits [32*i+31:32*i])
//   s_query_response_*       : per-port response (valid/ready/error/mac, mac
//                              port i at bits [48*i+47:48*i]); error and mac
//                              are broadcast, only valid selects the port
//   m_query_request_*        : request to the cache
//   m_query_response_*       : response from the cache
//   outstanding              : queries issued and not yet answered
//   stray_response           : one-cycle pulse after a response that had no
//                              matching outstanding query
// ---------------------------------------------------------------------------
module arp_cache_query_arb
    import arp_pkg::*;
#(
    parameter int PORTS          = 4,
    parameter int TAG_FIFO_DEPTH = 4,
    parameter int CL_PORTS       = $clog2(PORTS)
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [PORTS-1:0]              s_query_request_valid,
    output logic [PORTS-1:0]              s_query_request_ready,
    input  logic [PORTS*IP_W-1:0]         s_query_request_ip,

    output logic [PORTS-1:0]              s_query_response_valid,
    input  logic [PORTS-1:0]              s_query_response_ready,
    output logic [PORTS-1:0]              s_query_response_error,
    output logic [PORTS*MAC_W-1:0]        s_query_response_mac,

    output logic                          m_query_request_valid,
    input  logic                          m_query_request_ready,
    output logic [IP_W-1:0]               m_query_request_ip,

    input  logic                          m_query_response_valid,
    output logic                          m_query_response_ready,
    input  logic                          m_query_response_error,
    input  logic [MAC_W-1:0]              m_query_response_mac,

    output logic [$clog2(TAG_FIFO_DEPTH):0] outstanding,
    output logic                          stray_response
);

    localparam int CNT_W = $clog2(TAG_FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(TAG_FIFO_DEPTH);
    localparam logic [CL_PORTS:0]   PORTS_SUM = (CL_PORTS+1)'(PORTS);
    localparam logic [CL_PORTS-1:0] LAST_PORT = CL_PORTS'(PORTS-1);

    // Registered state
    logic                m_valid_reg, m_valid_next;
    logic [IP_W-1:0]     m_ip_reg,    m_ip_next;
    logic [CL_PORTS-1:0] rr_ptr_reg,  rr_ptr_next;
    logic                stray_reg,   stray_next;

    // Arbitration
    logic [IP_W-1:0]     ip_arr [PORTS];
    logic [2*PORTS-1:0]  req_dbl;
    logic [PORTS-1:0]    req_rot;
    logic [CL_PORTS-1:0] rot_idx;
    logic                any_req;
    logic [CL_PORTS:0]   grant_sum;
    logic [CL_PORTS-1:0] grant_idx;
    logic                free;
    logic                grant_en;
    logic                grant;

    // Tag FIFO / response routing
    logic [CL_PORTS-1:0] head;
    logic [CNT_W-1:0]    count;
    logic                fifo_empty;
    logic                fifo_pop;
    query_resp_t         m_resp;

    assign m_resp = '{error: m_query_response_error, mac: m_query_response_mac};

    // Rotate the request vector so rr_ptr lands at bit 0, pick the lowest
    // set bit, then rotate the index back. The sum stays below 2*PORTS, so a
    // single conditional subtract is enough to wrap for any PORTS.
    always_comb begin
        req_dbl = {s_query_request_valid, s_query_request_valid};
        req_rot = req_dbl[rr_ptr_reg +: PORTS];
        rot_idx = '0;
        any_req = 1'b0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx = CL_PORTS'(i);
                any_req = 1'b1;
            end
        end
        grant_sum = {1'b0, rr_ptr_reg} + {1'b0, rot_idx};
        if (grant_sum >= PORTS_SUM) begin
            grant_idx = CL_PORTS'(grant_sum - PORTS_SUM);
        end else begin
            grant_idx = grant_sum[CL_PORTS-1:0];
        end
    end

    // The FIFO count already covers the query sitting in the output register,
    // and uses the registered value only: a pop in this cycle does not open
    // a slot until the next one.
    assign free     = !m_valid_reg || m_query_request_ready;
    assign grant_en = free && (count < DEPTH_CNT);
    assign grant    = grant_en && any_req;

    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
            assign ip_arr[gi]                  = s_query_request_ip[IP_W*gi +: IP_W];
            assign s_query_request_ready[gi]   = grant && (grant_idx == CL_PORTS'(gi));
            assign s_query_response_valid[gi]  = !fifo_empty && (head == CL_PORTS'(gi))
                                                 && m_query_response_valid;
            assign s_query_response_error[gi]  = m_resp.error;
            assign s_query_response_mac[MAC_W*gi +: MAC_W] = m_resp.mac;
        end
    endgenerate

    // With nothing outstanding the response is accepted and dropped so a
    // confused cache cannot wedge the port.
    assign m_query_response_ready = fifo_empty ? 1'b1 : s_query_response_ready[head];
    assign fifo_pop   = !fifo_empty && m_query_response_valid && m_query_response_ready;

    always_comb begin
        m_valid_next = m_valid_reg;
        m_ip_next    = m_ip_reg;
        rr_ptr_next  = rr_ptr_reg;
        if (grant) begin
            m_valid_next = 1'b1;
            m_ip_next    = ip_arr[grant_idx];
            rr_ptr_next  = (grant_idx == LAST_PORT) ? '0 : grant_idx + CL_PORTS'(1);
        end else if (m_query_request_ready) begin
            m_valid_next = 1'b0;
        end
        stray_next = fifo_empty && m_query_response_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_ip_reg    <= '0;
            rr_ptr_reg  <= '0;
            stray_reg   <= 1'b0;
        end else begin
            m_valid_reg <= m_valid_next;
            m_ip_reg    <= m_ip_next;
            rr_ptr_reg  <= rr_ptr_next;
            stray_reg   <= stray_next;
        end
    end

    arp_tag_fifo #(
        .WIDTH (CL_PORTS),
        .DEPTH (TAG_FIFO_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (grant_idx),
        .pop       (fifo_pop),
        .head      (head),
        .count     (count),
        .empty     (fifo_empty)
    );

    assign m_query_request_valid = m_valid_reg;
    assign m_query_request_ip    = m_ip_reg;
    assign outstanding           = count;
    assign stray_response        = stray_reg;

endmodule

// File: tb/tb_arp_cache_query_arb.sv
// ---------------------------------------------------------------------------
// tb_arp_cache_query_arb
// Scoreboard bench: requester queues feed the DUT, a bench-side cache model
// answers in order after a fixed delay, and per-port expected-response queues
// are filled at request acceptance and drained when the DUT delivers.
// ---------------------------------------------------------------------------
module tb_arp_cache_query_arb;
    import arp_pkg::*;

    localparam int PORTS = 4;
    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic                   clk;
    logic                   rst;
    logic [PORTS-1:0]       s_query_request_valid;
    logic [PORTS-1:0]       s_query_request_ready;
    logic [PORTS*32-1:0]    s_query_request_ip;
    logic [PORTS-1:0]       s_query_response_valid;
    logic [PORTS-1:0]       s_query_response_ready;
    logic [PORTS-1:0]       s_query_response_error;
    logic [PORTS*48-1:0]    s_query_response_mac;
    logic                   m_query_request_valid;
    logic                   m_query_request_ready;
    logic [31:0]            m_query_request_ip;
    logic                   m_query_response_valid;
    logic                   m_query_response_ready;
    logic                   m_query_response_error;
    logic [47:0]            m_query_response_mac;
    logic [2:0]             outstanding;
    logic                   stray_response;

    arp_cache_query_arb #(.PORTS(PORTS), .TAG_FIFO_DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .s_query_request_valid  (s_query_request_valid),
        .s_query_request_ready  (s_query_request_ready),
        .s_query_request_ip     (s_query_request_ip),
        .s_query_response_valid (s_query_response_valid),
        .s_query_response_ready (s_query_response_ready),
        .s_query_response_error (s_query_response_error),
        .s_query_response_mac   (s_query_response_mac),
        .m_query_request_valid  (m_query_request_valid),
        .m_query_request_ready  (m_query_request_ready),
        .m_query_request_ip     (m_query_request_ip),
        .m_query_response_valid (m_query_response_valid),
        .m_query_response_ready (m_query_response_ready),
        .m_query_response_error (m_query_response_error),
        .m_query_response_mac   (m_query_response_mac),
        .outstanding            (outstanding),
        .stray_response         (stray_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { int port; logic [31:0] ip; int cyc; } req_t;
    typedef struct packed { int port; logic [31:0] ip; bit stray; int rdy; } cent_t;
    typedef struct packed { logic err; logic [47:0] mac; logic [31:0] ip; } exp_t;

    logic [31:0] port_q [PORTS][$];
    exp_t        exp_q  [PORTS][$];
    req_t        m_exp [$];
    cent_t       cache_pipe [$];
    int          grant_log [$];
    int          deliv_log [$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          stray_seen = 0;
    bit          req_rdy, resp_en, lat_chk;
    logic [PORTS-1:0] rsp_rdy;

    // Reference model of arbitration state
    int          mdl_rr;
    bit          mdl_mvalid;
    int          mdl_cnt;
    bit          mdl_stray;

    logic [47:0] last_mac [PORTS];
    logic        last_err [PORTS];
    int          delivered [PORTS];

    function automatic logic [47:0] mac_of(input logic [31:0] ip);
        return {ip[15:0], ip} ^ 48'h0B0ACCA50F0E;
    endfunction

    function automatic logic err_of(input logic [31:0] ip);
        return ip[31:24] == 8'hEE;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit idle();
        for (int p = 0; p < PORTS; p++) begin
            if (port_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
        end
        return (m_exp.size() == 0) && (cache_pipe.size() == 0);
    endfunction

    function automatic void model_reset();
        mdl_rr     = 0;
        mdl_mvalid = 1'b0;
        mdl_cnt    = 0;
        mdl_stray  = 1'b0;
    endfunction

    // One clock: drive at negedge, sample 2 units later (before the posedge
    // that will consume the handshakes), then advance the model.
    task automatic tick();
        logic [PORTS-1:0] svalid, exp_rdy, exp_rsp_v;
        logic  exp_mready;
        int    pick;
        bit    rhs, stray_hs;
        cent_t ce;
        req_t  re;
        exp_t  ee;
        @(negedge clk);
        m_query_request_ready  = req_rdy;
        s_query_response_ready = rsp_rdy;
        for (int p = 0; p < PORTS; p++) begin
            if (port_q[p].size() > 0) begin
                s_query_request_valid[p]     = 1'b1;
                s_query_request_ip[32*p +: 32] = port_q[p][0];
            end else begin
                s_query_request_valid[p]     = 1'b0;
                s_query_request_ip[32*p +: 32] = '0;
            end
        end
        if (resp_en && cache_pipe.size() > 0 && cache_pipe[0].rdy <= cyc) begin
            m_query_response_valid = 1'b1;
            m_query_response_mac   = mac_of(cache_pipe[0].ip);
            m_query_response_error = err_of(cache_pipe[0].ip);
        end else begin
            m_query_response_valid = 1'b0;
            m_query_response_mac   = '0;
            m_query_response_error = 1'b0;
        end
        #2;
        check_eq("m_valid", m_query_request_valid, mdl_mvalid);
        check_eq("outstanding", outstanding, mdl_cnt);
        check_eq("stray", stray_response, mdl_stray);
        if (stray_response === 1'b1) stray_seen++;

        svalid  = s_query_request_valid;
        exp_rdy = '0;
        pick    = -1;
        if ((!mdl_mvalid || req_rdy) && mdl_cnt < DEPTH) begin
            for (int k = 0; k < PORTS; k++) begin
                int pk;
                pk = (mdl_rr + k) % PORTS;
                if (pick < 0 && svalid[pk]) pick = pk;
            end
        end
        if (pick >= 0) exp_rdy[pick] = 1'b1;
        check_eq("s_req_ready", s_query_request_ready, exp_rdy);

        // Cache accepts the query held in the output register
        if (m_query_request_valid && req_rdy) begin
            if (m_exp.size() == 0) begin
                check_eq("m_unexpected", 1, 0);
            end else begin
                re = m_exp.pop_front();
                check_eq("m_ip", m_query_request_ip, re.ip);
                if (lat_chk) check_eq("m_latency", cyc - re.cyc, 1);
                ce = '{port: re.port, ip: re.ip, stray: 1'b0, rdy: cyc + LAT};
                cache_pipe.push_back(ce);
            end
        end

        // Requesters whose query was accepted
        for (int p = 0; p < PORTS; p++) begin
            if (svalid[p] && s_query_request_ready[p]) begin
                re = '{port: p, ip: port_q[p].pop_front(), cyc: cyc};
                m_exp.push_back(re);
                ee = '{err: err_of(re.ip), mac: mac_of(re.ip), ip: re.ip};
                exp_q[p].push_back(ee);
                grant_log.push_back(p);
            end
        end

        // Response routing
        exp_rsp_v  = '0;
        exp_mready = 1'b1;
        rhs        = 1'b0;
        stray_hs   = 1'b0;
        if (m_query_response_valid && !cache_pipe[0].stray) begin
            exp_rsp_v[cache_pipe[0].port] = 1'b1;
            exp_mready = rsp_rdy[cache_pipe[0].port];
        end
        check_eq("s_rsp_valid", s_query_response_valid, exp_rsp_v);
        if (m_query_response_valid) check_eq("m_rsp_ready", m_query_response_ready, exp_mready);
        if (m_query_response_valid && m_query_response_ready) begin
            ce = cache_pipe.pop_front();
            if (ce.stray) begin
                stray_hs = 1'b1;
                $display("cyc %0d stray response ip=%h dropped", cyc, ce.ip);
            end else if (exp_q[ce.port].size() == 0) begin
                check_eq("rsp_unexpected", 1, 0);
            end else begin
                rhs = 1'b1;
                ee  = exp_q[ce.port].pop_front();
                check_eq("rsp_mac", s_query_response_mac[48*ce.port +: 48], ee.mac);
                check_eq("rsp_err", s_query_response_error[ce.port], ee.err);
                last_mac[ce.port] = s_query_response_mac[48*ce.port +: 48];
                last_err[ce.port] = s_query_response_error[ce.port];
                delivered[ce.port]++;
                deliv_log.push_back(ce.port);
                $display("cyc %0d rsp port=%0d ip=%h mac=%h err=%0d", cyc, ce.port,
                         ee.ip, last_mac[ce.port], last_err[ce.port]);
            end
        end

        if (pick >= 0) begin
            mdl_mvalid = 1'b1;
            mdl_rr     = (pick + 1) % PORTS;
        end else if (req_rdy) begin
            mdl_mvalid = 1'b0;
        end
        mdl_cnt   = mdl_cnt + ((pick >= 0) ? 1 : 0) - (rhs ? 1 : 0);
        mdl_stray = stray_hs;
        cyc++;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (!idle() && n < maxc) begin
            tick();
            n++;
        end
        check_eq("drain_done", idle(), 1);
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, d1, s0;
        rst = 1'b1;
        s_query_request_valid  = '0;
        s_query_request_ip     = '0;
        s_query_response_ready = '0;
        m_query_request_ready  = 1'b0;
        m_query_response_valid = 1'b0;
        m_query_response_error = 1'b0;
        m_query_response_mac   = '0;
        req_rdy = 1'b1; resp_en = 1'b1; lat_chk = 1'b1; rsp_rdy = '1;
        for (int p = 0; p < PORTS; p++) begin
            delivered[p] = 0; last_mac[p] = '0; last_err[p] = 1'b0;
        end
        model_reset();
        repeat (2) tick();
        check_eq("rst_m_ip", m_query_request_ip, 0);
        rst = 1'b0;

        // Single port query through the 3-cycle cache
        port_q[2].push_back(32'hC0A80101);
        drain(50);
        check_eq("single_cnt", delivered[2], 1);
        check_eq("single_mac", last_mac[2], 48'h0A0B0C0D0E0F);
        check_eq("single_err", last_err[2], 0);
        check_eq("single_other", delivered[0] + delivered[1] + delivered[3], 0);

        // Fairness with all ports continuously requesting
        grant_log.delete();
        for (int p = 0; p < PORTS; p++)
            for (int k = 0; k < 6; k++)
                port_q[p].push_back(32'h0A000000 | (p << 8) | k);
        drain(400);
        check_eq("rr_grants", grant_log.size(), 6 * PORTS);
        check_eq("rr_first", grant_log[0], 3);
        for (int i = 1; i < grant_log.size(); i++)
            check_eq("rr_order", grant_log[i], (grant_log[0] + i) % PORTS);

        // Full tag FIFO with responses withheld
        resp_en = 1'b0;
        for (int k = 0; k < 6; k++) port_q[0].push_back(32'h0B000000 | k);
        repeat (12) tick();
        check_eq("full_issued", cache_pipe.size(), DEPTH);
        check_eq("full_outstanding", outstanding, DEPTH);
        check_eq("full_left", port_q[0].size(), 2);
        check_eq("full_ready", s_query_request_ready, 0);
        resp_en = 1'b1;
        drain(100);

        // Head response stalled by its requester
        d1 = delivered[1];
        rsp_rdy[1] = 1'b0;
        port_q[1].push_back(32'h0C000001);
        tick();
        port_q[3].push_back(32'h0C000003);
        n = 0;
        while (!m_query_response_valid && n < 20) begin tick(); n++; end
        check_eq("stall_seen", m_query_response_valid, 1);
        repeat (4) begin
            tick();
            check_eq("stall_m_ready", m_query_response_ready, 0);
            check_eq("stall_p1", delivered[1], d1);
        end
        rsp_rdy[1] = 1'b1;
        drain(50);
        check_eq("stall_order_a", deliv_log[deliv_log.size()-2], 1);
        check_eq("stall_order_b", deliv_log[deliv_log.size()-1], 3);

        // Stray response and miss pass-through
        s0 = stray_seen;
        cache_pipe.push_back('{port: 0, ip: 32'h12345678, stray: 1'b1, rdy: cyc});
        drain(20);
        check_eq("stray_count", stray_seen - s0, 1);
        port_q[0].push_back(32'hEE0000A5);
        drain(50);
        check_eq("miss_err", last_err[0], 1);
        check_eq("miss_mac", last_mac[0], mac_of(32'hEE0000A5));

        // Random traffic with random backpressure on both sides
        lat_chk = 1'b0;
        for (int k = 0; k < 40; k++) begin
            int rp;
            rp = $urandom_range(0, PORTS - 1);
            port_q[rp].push_back(((k % 7 == 0) ? 32'hEE000000 : 32'h0D000000) | $urandom_range(0, 65535));
        end
        n = 0;
        while (!idle() && n < 1500) begin
            req_rdy = ($urandom_range(0, 3) != 0);
            rsp_rdy = PORTS'($urandom);
            tick();
            n++;
        end
        req_rdy = 1'b1; rsp_rdy = '1; lat_chk = 1'b1;
        drain(100);

        // Asynchronous reset with three queries outstanding
        resp_en = 1'b0;
        port_q[0].push_back(32'h0E000000);
        port_q[1].push_back(32'h0E000001);
        port_q[2].push_back(32'h0E000002);
        n = 0;
        while (cache_pipe.size() < 3 && n < 20) begin tick(); n++; end
        tick();
        check_eq("pre_rst_outstanding", outstanding, 3);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_m_valid", m_query_request_valid, 0);
        check_eq("arst_m_ip", m_query_request_ip, 0);
        check_eq("arst_outstanding", outstanding, 0);
        check_eq("arst_stray", stray_response, 0);
        check_eq("arst_s_rsp_valid", s_query_response_valid, 0);
        model_reset();
        for (int p = 0; p < PORTS; p++) begin
            port_q[p].delete();
            exp_q[p].delete();
        end
        m_exp.delete();
        foreach (cache_pipe[i]) cache_pipe[i].stray = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        s0 = stray_seen;
        resp_en = 1'b1;
        drain(50);
        check_eq("post_rst_strays", stray_seen - s0, 3);
        d1 = delivered[3];
        port_q[3].push_back(32'hC0A80303);
        drain(50);
        check_eq("post_rst_p3", delivered[3] - d1, 1);
        check_eq("post_rst_mac", last_mac[3], mac_of(32'hC0A80303));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
